// File: rtl/wb_stage_hs_if.sv
// rtl/wb_stage_hs_if.sv - writeback stage bus: instruction inputs, syscall handshake, writeback outputs
interface wb_stage_hs_if #(
  parameter int XLEN     = 64,
  parameter int NUM_ARGS = 8,
  parameter int CNT_W    = 64
);
  logic                     inst_valid;
  logic [4:0]               inst_rd;
  logic                     inst_en_rd;
  logic                     inst_is_load;
  logic                     inst_is_store;
  logic                     inst_is_csr;
  logic                     inst_is_ecall;
  logic [XLEN-1:0]          alu_result;
  logic [XLEN-1:0]          mem_result;
  logic [XLEN-1:0]          ecall_num_in;
  logic [NUM_ARGS*XLEN-1:0] ecall_args_in;
  logic                     ecall_req;
  logic [XLEN-1:0]          ecall_num;
  logic [NUM_ARGS*XLEN-1:0] ecall_args;
  logic                     ecall_ack;
  logic [XLEN-1:0]          ecall_ret;
  logic [XLEN-1:0]          result;
  logic [4:0]               rd;
  logic                     en_rd;
  logic                     stall;
  logic                     ecall_timeout;
  logic [CNT_W-1:0]         retired;

  // master = pipeline/syscall side, slave = the writeback stage
  modport master (
    output inst_valid, inst_rd, inst_en_rd, inst_is_load, inst_is_store, inst_is_csr,
           inst_is_ecall, alu_result, mem_result, ecall_num_in, ecall_args_in,
           ecall_ack, ecall_ret,
    input  ecall_req, ecall_num, ecall_args, result, rd, en_rd, stall, ecall_timeout, retired
  );

  modport slave (
    input  inst_valid, inst_rd, inst_en_rd, inst_is_load, inst_is_store, inst_is_csr,
           inst_is_ecall, alu_result, mem_result, ecall_num_in, ecall_args_in,
           ecall_ack, ecall_ret,
    output ecall_req, ecall_num, ecall_args, result, rd, en_rd, stall, ecall_timeout, retired
  );
endinterface

// File: rtl/wb_stage_hs.sv
// rtl/wb_stage_hs.sv - writeback stage with result mux, retire counter and ecall handshake
module wb_stage_hs #(
  parameter int XLEN           = 64,
  parameter int NUM_ARGS       = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 64
) (
  input  logic          clk,
  input  logic          reset,
  wb_stage_hs_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t                   state_q, state_d;
  logic                     req_q, req_d;
  logic [XLEN-1:0]          num_q, num_d;
  logic [NUM_ARGS*XLEN-1:0] args_q, args_d;
  logic [XLEN-1:0]          ret_q, ret_d;
  logic [TW-1:0]            cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic [CNT_W-1:0]         retired_q, retired_d;
  logic                     stall;

  always_comb begin
    state_d   = state_q;
    req_d     = 1'b0;
    num_d     = num_q;
    args_d    = args_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    stall     = 1'b0;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (bus.inst_valid && bus.inst_is_ecall) begin
          stall   = 1'b1;
          num_d   = bus.ecall_num_in;
          args_d  = bus.ecall_args_in;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // ack wins over a timeout landing in the same cycle
        if (bus.ecall_ack) begin
          ret_d   = bus.ecall_ret;
          state_d = S_DONE;
        end else if (TO_EN && cnt_q == TMAX) begin
          ret_d     = '1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
          req_d = 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.inst_valid && !stall) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      num_q     <= '0;
      args_q    <= '0;
      ret_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      num_q     <= num_d;
      args_q    <= args_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    if (bus.inst_is_load || bus.inst_is_store || bus.inst_is_csr) begin
      bus.result = bus.mem_result;
    end else if (bus.inst_is_ecall) begin
      bus.result = ret_q;
    end else begin
      bus.result = bus.alu_result;
    end
  end

  // an ecall only writes its destination once the return value is latched
  assign bus.en_rd = bus.inst_valid && bus.inst_en_rd && (bus.inst_rd != 5'd0) &&
                     (!bus.inst_is_ecall || state_q == S_DONE);
  assign bus.rd            = bus.inst_rd;
  assign bus.stall         = stall;
  assign bus.ecall_req     = req_q;
  assign bus.ecall_num     = num_q;
  assign bus.ecall_args    = args_q;
  assign bus.ecall_timeout = timeout_q;
  assign bus.retired       = retired_q;
endmodule

// File: tb/tb_wb_stage_hs.sv
// tb/tb_wb_stage_hs.sv - scoreboard bench for wb_stage_hs
module tb_wb_stage_hs;
  localparam int XLEN = 64;
  localparam int NA   = 8;
  localparam int TO   = 4;
  localparam int CW   = 64;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  typedef struct {
    logic [XLEN-1:0]    num;
    logic [NA*XLEN-1:0] args;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_hs_if #(.XLEN(XLEN), .NUM_ARGS(NA), .CNT_W(CW)) bus ();

  wb_stage_hs #(.XLEN(XLEN), .NUM_ARGS(NA), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_t  wb_q[$];
  req_t rq_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   req_pulses = 0;
  logic req_prev = 1'b0;
  logic [CW-1:0] exp_retired = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.inst_valid    = 1'b0;
    bus.inst_rd       = 5'd0;
    bus.inst_en_rd    = 1'b0;
    bus.inst_is_load  = 1'b0;
    bus.inst_is_store = 1'b0;
    bus.inst_is_csr   = 1'b0;
    bus.inst_is_ecall = 1'b0;
    bus.alu_result    = '0;
    bus.mem_result    = '0;
    bus.ecall_num_in  = '0;
    bus.ecall_args_in = '0;
    bus.ecall_ack     = 1'b0;
    bus.ecall_ret     = '0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // wait for the sampling point and let the scoreboard consume DUT output
  task automatic sample();
    wb_t  w;
    req_t r;
    @(negedge clk);
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (bus.en_rd) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 64'd1, 64'd0);
        end else begin
          w = wb_q.pop_front();
          check("wb_rd", 64'(bus.rd), 64'(w.rd));
          check("wb_data", bus.result, w.data);
        end
      end
      if (bus.ecall_req && !req_prev) begin
        req_pulses++;
        if (rq_q.size() == 0) begin
          check("req_unexpected", 64'd1, 64'd0);
        end else begin
          r = rq_q.pop_front();
          check("req_num", bus.ecall_num, r.num);
          check("req_arg0", bus.ecall_args[XLEN-1:0], r.args[XLEN-1:0]);
          check("req_args_all", 64'(bus.ecall_args == r.args), 64'd1);
        end
      end
      req_prev = bus.ecall_req;
    end
  endtask

  task automatic do_ecall(input logic [XLEN-1:0] num, input logic [XLEN-1:0] a0,
                          input logic [4:0] rd, input int ack_after,
                          input logic [XLEN-1:0] ret);
    logic [NA*XLEN-1:0] args;
    logic [XLEN-1:0]    exp_res;
    wb_t  w;
    req_t r;
    int   stalls;
    int   reqs;
    bit   done;
    bit   exp_to;
    exp_to  = (ack_after == 0);
    exp_res = exp_to ? '1 : ret;
    args = '0;
    args[XLEN-1:0] = a0;
    for (int i = 1; i < NA; i++) args[i*XLEN +: XLEN] = {$urandom, $urandom};
    drive_idle();
    bus.inst_valid    = 1'b1;
    bus.inst_is_ecall = 1'b1;
    bus.inst_en_rd    = 1'b1;
    bus.inst_rd       = rd;
    bus.ecall_num_in  = num;
    bus.ecall_args_in = args;
    r.num = num;
    r.args = args;
    rq_q.push_back(r);
    if (rd != 5'd0) begin
      w.rd = rd;
      w.data = exp_res;
      wb_q.push_back(w);
    end
    stalls = 0;
    reqs = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      sample();
      if (bus.stall) begin
        stalls++;
      end else begin
        done = 1'b1;
        check("done_req_low", 64'(bus.ecall_req), 64'd0);
        check("done_result", bus.result, exp_res);
        check("done_en_rd", 64'(bus.en_rd), 64'(rd != 5'd0));
        check("done_timeout", 64'(bus.ecall_timeout), 64'(exp_to));
        check("stall_cycles", 64'(stalls), exp_to ? 64'(TO + 1) : 64'(ack_after + 1));
        check("req_cycles", 64'(reqs), exp_to ? 64'(TO) : 64'(ack_after));
      end
      if (bus.ecall_req) begin
        reqs++;
        check("req_num_stable", bus.ecall_num, num);
        if (ack_after != 0 && reqs == ack_after) begin
          bus.ecall_ack = 1'b1;
          bus.ecall_ret = ret;
        end
      end
      if (!done) begin
        adv();
        bus.ecall_ack = 1'b0;
        bus.ecall_ret = '0;
      end
    end
    if (!done) check("ecall_budget", 64'd0, 64'd1);
    exp_retired = exp_retired + 1;
  endtask

  initial begin
    int p0;
    drive_idle();
    reset = 1'b1;
    adv();
    sample();
    check("rst_retired", bus.retired, 64'd0);
    check("rst_req", 64'(bus.ecall_req), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_timeout", 64'(bus.ecall_timeout), 64'd0);
    check("rst_num", bus.ecall_num, 64'd0);
    adv();
    reset = 1'b0;

    // ALU op, rd=5
    bus.inst_valid = 1'b1;
    bus.inst_en_rd = 1'b1;
    bus.inst_rd    = 5'd5;
    bus.alu_result = 64'h2A;
    wb_q.push_back('{rd: 5'd5, data: 64'h2A});
    sample();
    check("alu_en_rd", 64'(bus.en_rd), 64'd1);
    check("alu_result", bus.result, 64'h2A);
    check("alu_stall", 64'(bus.stall), 64'd0);
    exp_retired = exp_retired + 1;
    adv();
    drive_idle();
    sample();
    check("alu_retired", bus.retired, exp_retired);

    // load to x0 is suppressed but still retires
    adv();
    bus.inst_valid   = 1'b1;
    bus.inst_en_rd   = 1'b1;
    bus.inst_is_load = 1'b1;
    bus.inst_rd      = 5'd0;
    bus.mem_result   = 64'hFF;
    bus.alu_result   = 64'h1234;
    sample();
    check("ld_x0_en_rd", 64'(bus.en_rd), 64'd0);
    check("ld_result", bus.result, 64'hFF);
    exp_retired = exp_retired + 1;
    adv();
    drive_idle();
    sample();
    check("ld_retired", bus.retired, exp_retired);

    // ecall acknowledged on first WAIT cycle
    adv();
    do_ecall(64'd93, 64'd7, 5'd10, 1, 64'h10);
    adv();
    drive_idle();
    sample();
    check("ecall_retired", bus.retired, exp_retired);
    check("ecall_no_timeout", 64'(bus.ecall_timeout), 64'd0);

    // ecall left to time out
    adv();
    do_ecall(64'd64, 64'd3, 5'd11, 0, 64'h0);
    adv();
    drive_idle();
    sample();
    check("to_retired", bus.retired, exp_retired);
    check("to_pulse_one_cycle", 64'(bus.ecall_timeout), 64'd0);

    // reset while waiting on the syscall unit
    adv();
    bus.inst_valid    = 1'b1;
    bus.inst_is_ecall = 1'b1;
    bus.inst_en_rd    = 1'b1;
    bus.inst_rd       = 5'd12;
    bus.ecall_num_in  = 64'd5;
    bus.ecall_args_in = '0;
    rq_q.push_back('{num: 64'd5, args: '0});
    sample();
    adv();
    sample();
    check("rstw_req_high", 64'(bus.ecall_req), 64'd1);
    reset = 1'b1;
    drive_idle();
    adv();
    sample();
    check("rstw_req", 64'(bus.ecall_req), 64'd0);
    check("rstw_stall", 64'(bus.stall), 64'd0);
    check("rstw_retired", bus.retired, 64'd0);
    exp_retired = '0;
    reset = 1'b0;

    // bubbles flagged as ecall, with a stray ack outside WAIT
    for (int i = 0; i < 4; i++) begin
      adv();
      drive_idle();
      bus.inst_is_ecall = 1'b1;
      bus.inst_en_rd    = 1'b1;
      bus.inst_rd       = 5'd3;
      if (i == 1) begin
        bus.ecall_ack = 1'b1;
        bus.ecall_ret = 64'h55;
      end
      sample();
      check("bub_req", 64'(bus.ecall_req), 64'd0);
      check("bub_stall", 64'(bus.stall), 64'd0);
      check("bub_en_rd", 64'(bus.en_rd), 64'd0);
      check("bub_ret_kept", bus.result, 64'd0);
    end
    check("bub_retired", bus.retired, exp_retired);

    // back-to-back ecalls
    p0 = req_pulses;
    adv();
    do_ecall(64'd1, 64'h11, 5'd12, 1, 64'hA1);
    adv();
    do_ecall(64'd2, 64'h22, 5'd13, 2, 64'hA2);
    adv();
    drive_idle();
    sample();
    check("b2b_pulses", 64'(req_pulses - p0), 64'd2);
    check("b2b_retired", bus.retired, exp_retired);
    check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    check("req_queue_empty", 64'(rq_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_stage_hs.md
Name: wb_stage_hs

Overview:
- Parametrised writeback stage for the in-order RISC-V pipeline.
- Selects the writeback result (ALU, memory/CSR, or ecall return) and drives the register-file write port.
- Services ecall through a request/acknowledge handshake to an external syscall unit, with a bounded-wait timeout.
- Keeps a retired-instruction counter.
- Sits after MEM; its stall output freezes all earlier stages.

Parameters:
- XLEN, 64, datapath width of results, arguments and the ecall number.
- NUM_ARGS, 8, number of argument registers (a0..a[NUM_ARGS-1]) forwarded on ecall; range 1..8.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before forced completion; 0 disables the timeout.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_valid  in  1  1 = real instruction in WB; 0 = bubble
- inst_rd  in  5  destination register
- inst_en_rd  in  1  instruction writes rd
- inst_is_load / inst_is_store / inst_is_csr / inst_is_ecall  in  1 each  decoded class flags
- alu_result  in  XLEN  ALU result
- mem_result  in  XLEN  load/CSR result
- ecall_num_in  in  XLEN  a7 value
- ecall_args_in  in  NUM_ARGS*XLEN  a0 in bits [XLEN-1:0], then a1, a2, ...
- ecall_req  out  1  syscall request
- ecall_num  out  XLEN  latched call number
- ecall_args  out  NUM_ARGS*XLEN  latched arguments
- ecall_ack  in  1  syscall unit done
- ecall_ret  in  XLEN  syscall return value, valid with ecall_ack
- result  out  XLEN  writeback data
- rd  out  5  writeback register
- en_rd  out  1  register-file write enable
- stall  out  1  hold all earlier stages
- ecall_timeout  out  1  one-cycle pulse on forced completion
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous): state=IDLE, ecall_req=0, ecall_num=0, ecall_args=0, latched return=0, timeout counter=0, ecall_timeout=0, retired=0.
  - Reset during WAIT drops ecall_req at that edge and discards any outstanding call.
- FSM states IDLE, WAIT, DONE. All transitions occur at the clock edge.
  - IDLE: if inst_valid & inst_is_ecall, then stall=1 (combinational, same cycle); latch ecall_num_in/ecall_args_in; go to WAIT. Otherwise stall=0 and the FSM stays in IDLE.
  - WAIT: ecall_req=1 (registered), stall=1, ecall_num/ecall_args held stable.
    - If ecall_ack=1: latch ecall_ret, go to DONE. Ack is sampled in the same cycle req is seen high.
    - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1: latch all-ones as the return value, pulse ecall_timeout in the DONE cycle, go to DONE.
    - Otherwise increment the counter.
    - Ack takes priority over timeout when both occur in the same cycle.
  - DONE: ecall_req=0, stall=0, result=latched return, the ecall retires, counter cleared, go to IDLE.
  - Minimum ecall residency in WB is 3 cycles: arrival (IDLE), WAIT with ack, DONE.
  - In WAIT, instruction inputs are ignored; the stall holds them upstream.
  - ecall_ack outside WAIT is ignored.
- Result mux (combinational):
  - inst_is_load | inst_is_store | inst_is_csr selects mem_result.
  - Else inst_is_ecall selects the latched return value.
  - Else alu_result.
- rd = inst_rd always.
- en_rd = inst_valid & inst_en_rd & (inst_rd != 0) & (!inst_is_ecall | state==DONE).
  - x0 writes are suppressed.
  - An ecall writes its destination only in DONE.
- Retire counter: retired increments by 1 on each cycle with inst_valid & !stall; it wraps modulo 2^CNT_W. Bubbles and stalled cycles do not count.
- Back-to-back ecalls: an ecall arriving in the cycle after DONE starts a fresh IDLE->WAIT sequence. The latched return value stays valid until the next latch.

Test Plan:
- Reset, then ALU op with rd=5, alu_result=0x2A, inst_valid=1 -> same cycle: en_rd=1, result=0x2A, stall=0; next cycle retired=1.
- Load with rd=0, mem_result=0xFF -> en_rd=0, result=0xFF, retired increments by 1.
- ecall with a7=93, a0=7, ack with ecall_ret=0x10 on the first WAIT cycle -> stall=1 for 2 cycles; ecall_req=1 for 1 cycle with ecall_num=93 and arg0=7; DONE cycle result=0x10, en_rd=1; retired increments by exactly 1.
- TIMEOUT_CYCLES=4, ecall with no ack -> ecall_req high for 4 cycles; DONE result=all-ones, ecall_timeout=1 for exactly 1 cycle, stall drops.
- ecall in WAIT, reset asserted -> next cycle ecall_req=0, stall=0, retired=0, state IDLE.
- Bubble stream with inst_is_ecall=1, inst_valid=0 -> no req, stall=0, en_rd=0, retired unchanged. Then back-to-back valid ecalls -> two separate req pulses and two retirements.
